data_ram_responder: RTL and testbench



---
 rtl/data_ram_responder_pkg.sv | 17 +
 rtl/data_ram_responder_lane_align.sv | 50 +++++
 rtl/data_ram_responder.sv | 122 ++++++++++++
 tb/tb_data_ram_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_responder_pkg.sv
// Shared funct3 encodings and FSM state type for the data RAM responder.
package ram_resp_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } resp_state_t;

endpackage

// File: rtl/data_ram_responder_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module lane_align
  import ram_resp_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        align_err
);

  logic [31:0] rshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rshift = rword >> {addr_lo, 3'b000};
  assign rbyte  = rshift[7:0];
  assign rhalf  = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be        = 4'b0000;
    wdata_sh  = '0;
    rdata_ext = '0;
    align_err = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'd0, rbyte};
      end
      F3_H, F3_HU: begin
        align_err = addr_lo[0];
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = (funct3 == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'd0, rhalf};
      end
      F3_W: begin
        align_err = (addr_lo != 2'b00);
        be        = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_ram_responder.sv
// Load/store responder: one request at a time, programmable wait states,
// byte/half/word access to a word RAM, flagged errors instead of side effects.
module data_ram_responder
  import ram_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  resp_state_t   state;
  logic [CW-1:0] wait_cnt;

  logic          write_p0;
  logic [2:0]    funct3_p0;
  logic [31:0]   addr_p0;
  logic [31:0]   wdata_p0;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   rdata_ext;
  logic          align_err;
  logic          f3_err;
  logic          store_err;
  logic          range_err;
  logic          access_err;

  assign req_ready  = (state == IDLE) & ~rst;
  assign resp_valid = (state == RESP);

  assign word_idx = addr_p0[AW+1:2];
  assign rword    = mem[word_idx];

  lane_align u_lane_align (
    .funct3    (funct3_p0),
    .addr_lo   (addr_p0[1:0]),
    .wdata     (wdata_p0),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .align_err (align_err)
  );

  assign f3_err     = !(funct3_p0 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign store_err  = write_p0 & ((funct3_p0 == F3_BU) | (funct3_p0 == F3_HU));
  assign range_err  = ({2'b00, addr_p0[31:2]} >= 32'(DEPTH_WORDS));
  assign access_err = f3_err | store_err | align_err | range_err;

  // Request capture: data only, held untouched until the next accept
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      write_p0  <= req_write;
      funct3_p0 <= req_funct3;
      addr_p0   <= req_addr;
      wdata_p0  <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (WAIT_CYCLES > 0) begin
              state    <= WAIT;
              wait_cnt <= CW'(WAIT_CYCLES - 1);
            end else begin
              state <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= ACCESS;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        ACCESS: begin
          resp_err   <= access_err;
          resp_rdata <= (access_err || write_p0) ? 32'd0 : rdata_ext;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Access stage: the RAM only changes on the single ACCESS edge
  always_ff @(posedge clk) begin
    if (state == ACCESS && write_p0 && !access_err && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed plus randomized bench for data_ram_responder against a byte-array model.
module tb_data_ram_responder;

  localparam int DEPTH = 256;
  localparam int WAITC = 2;
  localparam int MBYTES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  logic [7:0] refm [MBYTES];

  data_ram_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V load/store semantics on a little-endian byte array
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] v;
    n  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    er = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
         || (w && f3 >= 3'd4) || ((a % n) != 0) || ((a / 4) >= DEPTH);
    rd = 32'd0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < n; i++) refm[a + i] = d[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v + (32'(refm[a + i]) << (8 * i));
        if (f3 == 3'd0 && v[7])  v = v - 32'd256;
        if (f3 == 3'd1 && v[15]) v = v - 32'd65536;
        rd = v;
      end
    end
  endtask

  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input int hold,
                     output logic [31:0] rd, output logic er);
    logic [31:0] erd;
    logic        eer;
    int          k;
    model(w, f3, a, d, erd, eer);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    k = 1;
    while (!resp_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!resp_valid) begin
      $display("FAIL timeout: no response within %0d cycles", k);
      $fatal(1, "timeout");
    end
    chk("latency", 32'(k), 32'(WAITC + 2));
    rd = resp_rdata;
    er = resp_err;
    chk("rdata", rd, erd);
    chk("err", 32'(er), 32'(eer));
    for (int i = 0; i < hold; i++) begin
      resp_ready = 1'b0;
      req_valid = ~i[0]; req_write = 1'b1; req_funct3 = 3'd2;
      req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, erd);
      chk("hold_err", 32'(resp_err), 32'(eer));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("resp_valid_clear", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
    for (int i = 0; i < MBYTES; i++) refm[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < MBYTES / 4; i++) txn(1'b1, 3'd2, 32'(4 * i), 32'd0, 0, rd, er);

    // Word store/load round trip
    txn(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, rd, er);
    txn(1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
    chk("lw_deadbeef", rd, 32'hDEAD_BEEF);

    txn(1'b1, 3'd0, 32'h13, 32'h0000_0080, 0, rd, er);
    txn(1'b0, 3'd0, 32'h13, 32'd0, 0, rd, er);
    chk("lb_sext", rd, 32'hFFFF_FF80);
    txn(1'b0, 3'd4, 32'h13, 32'd0, 0, rd, er);
    chk("lbu_zext", rd, 32'h0000_0080);
    txn(1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
    chk("lw_after_sb", rd, 32'h80AD_BEEF);

    txn(1'b1, 3'd1, 32'h12, 32'h0000_1234, 0, rd, er);
    txn(1'b0, 3'd1, 32'h12, 32'd0, 0, rd, er);
    chk("lh_1234", rd, 32'h0000_1234);
    txn(1'b1, 3'd1, 32'h11, 32'h0000_5678, 0, rd, er);
    chk("sh_misaligned_err", 32'(er), 32'd1);
    txn(1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
    chk("lw_after_sh", rd, 32'h1234_BEEF);

    txn(1'b0, 3'd2, 32'h400, 32'd0, 0, rd, er);
    chk("range_err", 32'(er), 32'd1);
    chk("range_rdata", rd, 32'd0);
    txn(1'b0, 3'd3, 32'h10, 32'd0, 0, rd, er);
    chk("f3_3_err", 32'(er), 32'd1);
    txn(1'b1, 3'd4, 32'h10, 32'h0000_00AA, 0, rd, er);
    chk("sbu_err", 32'(er), 32'd1);
    txn(1'b0, 3'd2, 32'h8000_0010, 32'd0, 0, rd, er);
    chk("high_addr_err", 32'(er), 32'd1);

    // Backpressure with stray requests, then confirm none landed
    txn(1'b0, 3'd2, 32'h10, 32'd0, 5, rd, er);
    txn(1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
    chk("no_stray_write", rd, 32'h1234_BEEF);

    // Reset during WAIT aborts the store
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h20; req_wdata = 32'h1111_1111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_wait_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_wait_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    txn(1'b0, 3'd2, 32'h20, 32'd0, 0, rd, er);
    chk("aborted_store", rd, 32'd0);

    // Asynchronous reset drops a pending response mid-cycle
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (WAITC + 1) @(posedge clk);
    #1;
    chk("pre_rst_resp_valid", 32'(resp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("async_rst_rdata", resp_rdata, 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;

    for (int n = 0; n < 200; n++) begin
      w  = 1'($urandom);
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 7)) : 3'd2;
      case ($urandom_range(0, 9))
        0:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
        1:       a = $urandom | 32'h8000_0000;
        default: a = 32'($urandom_range(0, MBYTES - 4));
      endcase
      txn(w, f3, a, $urandom, 0, rd, er);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
